// File: rtl/lane_train_ctrl.sv
// Link-training sequencer: steps Gen3/Gen4 ordered-set phases, then hands the lane to transport data.
// Latency: all outputs registered; a state decision made at edge N is visible right after edge N.
// Backpressure: none; phases advance only on os_sent boundaries, and a per-phase timeout traps to FAIL.
module lane_train_ctrl #(
  parameter int TX_MIN  = 2,
  parameter int RX_REQ  = 2,
  parameter int TIMEOUT = 1000,
  parameter int CNT_W   = 10
) (
  input  logic       fsm_clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       gen4,
  input  logic [3:0] os_in,
  input  logic       os_sent,
  output logic [3:0] d_sel,
  output logic       data_os,
  output logic       link_up,
  output logic       train_fail,
  output logic [2:0] state
);

  localparam int TXW = $clog2(TX_MIN + 1);
  localparam int RXW = $clog2(RX_REQ + 1);

  typedef enum logic [2:0] {
    S_DIS  = 3'd0,
    S_PH0  = 3'd1,
    S_PH1  = 3'd2,
    S_PH2  = 3'd3,
    S_PH3  = 3'd4,
    S_ACT  = 3'd5,
    S_FAIL = 3'd6
  } state_t;

  state_t           st_q, st_nxt;
  logic             gen_q, gen_nxt;
  logic [TXW-1:0]   tx_cnt, tx_eff, tx_nxt;
  logic [RXW-1:0]   rx_cnt, rx_eff, rx_nxt;
  logic [CNT_W-1:0] tmo_cnt, tmo_nxt;
  logic [3:0]       exp_code;
  logic             in_phase, adv, tmo_hit;
  logic [3:0]       d_sel_nxt;
  logic             data_os_nxt, link_up_nxt, train_fail_nxt;

  // Phase counters, advance/timeout qualification and next-state selection.
  always_comb begin
    st_nxt   = st_q;
    exp_code = {1'b0, st_q} + (gen_q ? 4'd4 : 4'd0);
    in_phase = (st_q == S_PH0) || (st_q == S_PH1) || (st_q == S_PH2) || (st_q == S_PH3);

    // Counter values including this cycle's events.
    tx_eff = tx_cnt;
    if (os_sent && (int'(tx_cnt) < TX_MIN)) tx_eff = tx_cnt + 1'b1;

    rx_eff = rx_cnt;
    if (os_in == exp_code) begin
      if (int'(rx_cnt) < RX_REQ) rx_eff = rx_cnt + 1'b1;
    end else if (os_in != 4'd0) begin
      rx_eff = '0;
    end

    adv     = in_phase && os_sent && (int'(tx_cnt) + 1 >= TX_MIN) && (int'(rx_eff) >= RX_REQ);
    tmo_hit = in_phase && (tmo_cnt == CNT_W'(TIMEOUT - 1));

    if (!enable) begin
      st_nxt = S_DIS;
    end else begin
      case (st_q)
        S_DIS:                      st_nxt = S_PH0;
        S_PH0, S_PH1, S_PH2, S_PH3: begin
          if (tmo_hit)  st_nxt = S_FAIL;
          else if (adv) st_nxt = state_t'(st_q + 3'd1);
        end
        S_ACT: begin
          // Partner restarting training: SLOS1, Gen3 TS1 or Gen4 TS1.
          if (os_in == 4'd1 || os_in == 4'd3 || os_in == 4'd5) st_nxt = S_PH0;
        end
        S_FAIL:                     st_nxt = S_FAIL;
        default:                    st_nxt = S_DIS;
      endcase
    end

    // Generation is captured only when leaving DISABLED.
    gen_nxt = gen_q;
    if (st_q == S_DIS && st_nxt != S_DIS) gen_nxt = gen4;

    // Any state change restarts all phase counters.
    if (st_nxt != st_q) begin
      tx_nxt  = '0;
      rx_nxt  = '0;
      tmo_nxt = '0;
    end else begin
      tx_nxt  = tx_eff;
      rx_nxt  = rx_eff;
      tmo_nxt = tmo_cnt + 1'b1;
    end
  end

  // Output decode from the upcoming state so every output is a register.
  always_comb begin
    d_sel_nxt      = 4'd0;
    data_os_nxt    = 1'b0;
    link_up_nxt    = 1'b0;
    train_fail_nxt = 1'b0;
    case (st_nxt)
      S_PH0, S_PH1, S_PH2, S_PH3: d_sel_nxt = {1'b0, st_nxt} + (gen_nxt ? 4'd4 : 4'd0);
      S_ACT: begin
        d_sel_nxt   = 4'd15;
        data_os_nxt = 1'b1;
        link_up_nxt = 1'b1;
      end
      S_FAIL:  train_fail_nxt = 1'b1;
      default: d_sel_nxt = 4'd0;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge fsm_clk) begin
    if (rst) begin
      st_q       <= S_DIS;
      gen_q      <= 1'b0;
      tx_cnt     <= '0;
      rx_cnt     <= '0;
      tmo_cnt    <= '0;
      d_sel      <= 4'd0;
      data_os    <= 1'b0;
      link_up    <= 1'b0;
      train_fail <= 1'b0;
    end else begin
      st_q       <= st_nxt;
      gen_q      <= gen_nxt;
      tx_cnt     <= tx_nxt;
      rx_cnt     <= rx_nxt;
      tmo_cnt    <= tmo_nxt;
      d_sel      <= d_sel_nxt;
      data_os    <= data_os_nxt;
      link_up    <= link_up_nxt;
      train_fail <= train_fail_nxt;
    end
  end

  assign state = st_q;

endmodule

// File: tb/tb_lane_train_ctrl.sv
// Bench for lane_train_ctrl: scripted partner stimulus with a d_sel transition scoreboard.
// Latency: checks sampled 1 time unit after the active edge, scoreboard sampled on the falling edge.
// Backpressure: none; all phases run on fixed cycle budgets.
module tb_lane_train_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable;
  logic       gen4;
  logic [3:0] os_in;
  logic       os_sent;
  logic [3:0] d_sel;
  logic       data_os;
  logic       link_up;
  logic       train_fail;
  logic [2:0] state;

  int n_chk  = 0;
  int n_fail = 0;
  int exp_q[$];
  logic       mon_en = 1'b0;
  logic [3:0] prev_dsel = 4'd0;

  lane_train_ctrl #(.TX_MIN(2), .RX_REQ(2), .TIMEOUT(16), .CNT_W(10)) dut (
    .fsm_clk(clk), .rst(rst), .enable(enable), .gen4(gen4), .os_in(os_in),
    .os_sent(os_sent), .d_sel(d_sel), .data_os(data_os), .link_up(link_up),
    .train_fail(train_fail), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One ordered set from the transmitter, partner echoing the current d_sel; 3 cycles apart.
  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      os_sent = 1'b1;
      os_in   = d_sel;
      cyc();
      os_sent = 1'b0;
      os_in   = 4'd0;
      cyc();
      cyc();
    end
  endtask

  // Scoreboard: every change of d_sel must match the next expected code.
  always @(negedge clk) begin
    if (mon_en && d_sel !== prev_dsel) begin
      if (exp_q.size() == 0) chk("dsel_unexpected", int'(d_sel), int'(prev_dsel));
      else                   chk("dsel_seq", int'(d_sel), exp_q.pop_front());
      prev_dsel = d_sel;
    end
  end

  initial begin
    rst = 1'b1; enable = 1'b0; gen4 = 1'b0; os_in = 4'd0; os_sent = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
    cyc();
    chk("rst_dsel", int'(d_sel), 0);
    chk("rst_data_os", int'(data_os), 0);
    chk("rst_link_up", int'(link_up), 0);
    chk("rst_train_fail", int'(train_fail), 0);
    chk("rst_state", int'(state), 0);
    mon_en = 1'b1;

    // Gen3 full training.
    exp_q.push_back(1);
    enable = 1'b1;
    cyc();
    chk("g3_enter_state", int'(state), 1);
    chk("g3_enter_dsel", int'(d_sel), 1);
    exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(4); exp_q.push_back(15);
    pulses(7);
    chk("g3_link_before", int'(link_up), 0);
    pulses(1);
    chk("g3_link_up", int'(link_up), 1);
    chk("g3_data_os", int'(data_os), 1);
    chk("g3_state_active", int'(state), 5);

    // Retrain from ACTIVE on Gen3 TS1, then re-complete.
    exp_q.push_back(1);
    os_in = 4'd3;
    cyc();
    os_in = 4'd0;
    chk("retrain_link", int'(link_up), 0);
    chk("retrain_state", int'(state), 1);
    exp_q.push_back(2); exp_q.push_back(3); exp_q.push_back(4); exp_q.push_back(15);
    pulses(8);
    chk("retrain_link_again", int'(link_up), 1);

    exp_q.push_back(0);
    enable = 1'b0;
    cyc();
    chk("dis_state", int'(state), 0);

    // Gen4 training; gen4 toggled mid-way must be ignored.
    gen4 = 1'b1;
    exp_q.push_back(5);
    enable = 1'b1;
    cyc();
    gen4 = 1'b0;
    exp_q.push_back(6); exp_q.push_back(7); exp_q.push_back(8); exp_q.push_back(15);
    pulses(3);
    gen4 = 1'b1;
    pulses(5);
    chk("g4_link_up", int'(link_up), 1);
    chk("g4_state", int'(state), 5);
    exp_q.push_back(0);
    enable = 1'b0;
    gen4 = 1'b0;
    cyc();

    // rx_cnt behaviour in PH0 Gen3: mismatches clear, zero holds.
    exp_q.push_back(1);
    enable = 1'b1;
    cyc();
    os_sent = 1'b1; cyc(); os_sent = 1'b0;            // tx_cnt = 1
    os_in = 4'd1; cyc(); os_in = 4'd2; cyc(); os_in = 4'd0;   // rx 1 then 0
    os_sent = 1'b1; cyc(); os_sent = 1'b0;
    chk("rx_clear_no_adv", int'(state), 1);
    os_in = 4'd1; cyc(); os_in = 4'd0; cyc();                 // rx 1, held
    os_sent = 1'b1; cyc(); os_sent = 1'b0;
    chk("rx_hold_no_adv", int'(state), 1);
    os_in = 4'd1; cyc(); os_in = 4'd0;                        // rx 2
    exp_q.push_back(2);
    os_sent = 1'b1; cyc(); os_sent = 1'b0;
    chk("rx_adv", int'(state), 2);
    exp_q.push_back(0);
    enable = 1'b0;
    cyc();

    // Timeout: FAIL exactly 16 cycles after phase entry.
    exp_q.push_back(1);
    enable = 1'b1;
    cyc();
    for (int i = 0; i < 15; i++) cyc();
    chk("tmo_not_yet", int'(state), 1);
    exp_q.push_back(0);
    cyc();
    chk("tmo_state", int'(state), 6);
    chk("tmo_fail_flag", int'(train_fail), 1);
    chk("tmo_dsel", int'(d_sel), 0);
    cyc(); cyc();
    chk("tmo_sticky", int'(train_fail), 1);
    enable = 1'b0;
    cyc();
    chk("tmo_dis_state", int'(state), 0);
    chk("tmo_dis_flag", int'(train_fail), 0);

    // Reset in PH2, then resume.
    exp_q.push_back(1);
    enable = 1'b1;
    cyc();
    exp_q.push_back(2); exp_q.push_back(3);
    pulses(4);
    chk("ph2_state", int'(state), 3);
    exp_q.push_back(0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("mid_rst_state", int'(state), 0);
    chk("mid_rst_dsel", int'(d_sel), 0);
    chk("mid_rst_link", int'(link_up), 0);
    exp_q.push_back(1);
    cyc();
    chk("resume_state", int'(state), 1);

    // Enable drop wins over a qualifying advance in PH1.
    exp_q.push_back(2);
    pulses(2);
    chk("ph1_state", int'(state), 2);
    pulses(1);
    exp_q.push_back(0);
    os_sent = 1'b1; os_in = 4'd2; enable = 1'b0;
    cyc();
    os_sent = 1'b0; os_in = 4'd0;
    chk("dis_over_adv", int'(state), 0);
    cyc(); cyc();

    chk("sb_drain", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
